pulse_xing_scheduler: RTL and testbench
=======================================

Name: pulse_xing_scheduler

Overview:
- Fast-domain (i_clk_f) scheduler that lets N_REQ independent pulse sources share one toggle-based fast-to-slow pulse crossing channel.
- Counts outstanding pulses per requester and grants the channel round-robin.
- Issues one single-cycle channel pulse plus a stable requester ID per grant.
- Enforces a minimum spacing between channel pulses so the slow-domain toggle/XOR detector never merges or drops pulses.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- CNT_W, 4, width of each per-requester pending counter; saturates at 2^CNT_W-1.
- MIN_GAP, 8, fast cycles from a channel pulse until the scheduler may arbitrate again. Must be ≥2. Integration must set it ≥ 3×ceil(T_slow/T_fast)+1.
- ID_W (localparam), max(1, clog2(N_REQ)), width of the channel ID.

Ports:
- i_clk_f  input  1  fast clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_enable  input  1  1 = scheduler may start new grants.
- i_req_pulse  input  N_REQ  per-requester single-cycle request pulses; multiple bits may be high in the same cycle.
- i_ovf_clr  input  1  synchronous clear of all o_overflow bits.
- o_pluse_f  output  1  single-cycle pulse to the crossing channel's toggle flop.
- o_chan_id  output  ID_W  granted requester. Stable from the o_pluse_f cycle through the end of HOLD.
- o_busy  output  1  high in ISSUE or HOLD.
- o_pending_any  output  1  OR of (pending[i] != 0), registered.
- o_overflow  output  N_REQ  sticky per-requester saturation flags.

Behaviour:
- Reset (asynchronous, i_reset=0):
  - state=IDLE; all pending counters=0.
  - o_pluse_f=0, o_chan_id=0, o_busy=0, o_pending_any=0, o_overflow=0.
  - gap counter=0; last_grant=N_REQ-1, so requester 0 has first priority.
- Reset mid-operation discards all pending counts and any in-flight grant. The companion crossing channel is reset by the same i_reset.
- Pending counters (every cycle, per i):
  - increment if i_req_pulse[i]=1.
  - decrement if requester i is granted in ISSUE.
  - increment and decrement together: no change.
  - increment at 2^CNT_W-1 without decrement: counter holds and o_overflow[i] is set.
  - at max with both increment and decrement: counter holds max, no overflow.
  - i_ovf_clr clears o_overflow; a same-cycle new overflow wins (bit stays 1).
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE:
    - if i_enable=1 and any pending != 0, select the first nonzero requester scanning last_grant+1, +2, … modulo N_REQ.
    - register the selection into o_chan_id and last_grant; next state ISSUE.
    - otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - o_pluse_f=1, o_busy=1; decrement pending[o_chan_id].
    - load gap counter with MIN_GAP-1; next state HOLD.
  - HOLD:
    - o_busy=1, o_chan_id held; gap counter decrements each cycle.
    - when the counter equals 1, next state IDLE (HOLD lasts MIN_GAP-1 cycles).
- Timing:
  - A request pulse in cycle t with the scheduler idle and no other pending produces o_pluse_f in cycle t+2.
  - Back-to-back grants produce o_pluse_f exactly MIN_GAP+1 cycles apart. Spacing is never less.
- i_enable:
  - Deassertion during ISSUE/HOLD does not abort the grant; only new grants from IDLE are blocked.
  - Requests are still counted while disabled.
- o_pending_any: registered from next-state counter values, so it reflects counts after the current cycle's updates.
- o_chan_id: changes only on IDLE→ISSUE; otherwise holds its last value, including in IDLE.

Test Plan:
- Single pulse on req[2] at cycle 10, idle, MIN_GAP=8 → o_pluse_f=1 only at cycle 12, o_chan_id=2 cycles 12–19, o_busy=1 cycles 12–19, pending[2] returns to 0.
- req=4'b1111 in one cycle → four pulses with IDs 0,1,2,3, each exactly 9 cycles apart. Then o_pending_any=0 and o_busy=0.
- Fairness: req[0] pulsed every cycle for 40 cycles, plus one req[3] pulse → ID 3 is granted no later than the second grant after it arrives. Grants never show ID 0 twice in a row while pending[3]≠0.
- Saturation with CNT_W=4: 17 pulses on req[1] while i_enable=0 → pending[1]=15, o_overflow[1]=1. Enable → exactly 15 pulses with ID 1. i_ovf_clr → o_overflow=0.
- i_enable drops during HOLD with 3 pending → the current HOLD completes and no new o_pluse_f appears. Re-enable → pulses resume, starting 1 cycle later plus the arbitration cycle.
- Assert i_reset low during HOLD with pending=5 → all outputs 0 immediately. After release with no requests, o_pluse_f stays 0 for 50 cycles.

Source files
------------

// File: rtl/pulse_xing_scheduler_if.sv
// pulse_xing_scheduler_if: request/grant bundle between pulse sources and the crossing scheduler.
//   i_enable       scheduler may start new grants
//   i_req_pulse    per-requester single-cycle request pulses
//   i_ovf_clr      synchronous clear of overflow flags
//   o_pluse_f      single-cycle pulse to the crossing channel toggle flop
//   o_chan_id      granted requester, stable through ISSUE and HOLD
//   o_busy         grant in flight (ISSUE or HOLD)
//   o_pending_any  any requester has pending pulses (registered)
//   o_overflow     sticky per-requester saturation flags
interface pulse_xing_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic             i_enable;
    logic [N_REQ-1:0] i_req_pulse;
    logic             i_ovf_clr;
    logic             o_pluse_f;
    logic [ID_W-1:0]  o_chan_id;
    logic             o_busy;
    logic             o_pending_any;
    logic [N_REQ-1:0] o_overflow;

    modport master (
        output i_enable, i_req_pulse, i_ovf_clr,
        input  o_pluse_f, o_chan_id, o_busy, o_pending_any, o_overflow
    );

    modport slave (
        input  i_enable, i_req_pulse, i_ovf_clr,
        output o_pluse_f, o_chan_id, o_busy, o_pending_any, o_overflow
    );
endinterface

// File: rtl/pulse_xing_scheduler.sv
// pulse_xing_scheduler: round-robin sharing of one fast-to-slow toggle pulse channel among N_REQ sources.
//   i_clk_f   fast clock, rising edge
//   i_reset   asynchronous active-low reset
//   bus       slave side of pulse_xing_scheduler_if (requests in; pulse, id, status out)
module pulse_xing_scheduler #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 4,
    parameter int MIN_GAP = 8
) (
    input logic                   i_clk_f,
    input logic                   i_reset,
    pulse_xing_scheduler_if.slave bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = $clog2(MIN_GAP);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       pending  [N_REQ];
    logic [CNT_W-1:0]       pend_nxt [N_REQ];
    logic [N_REQ-1:0]       ovf_set;
    logic [N_REQ-1:0]       nonzero_nxt;
    logic [N_REQ-1:0]       overflow;
    logic [GAP_W-1:0]       gap;
    logic [ID_W-1:0]        last_grant;
    logic [ID_W-1:0]        chan_id;
    logic [ID_W-1:0]        sel;
    logic [ID_W-1:0]        idx;
    logic                   found;
    logic                   pluse;
    logic                   busy;
    logic                   pending_any;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            logic inc, dec, at_max;
            inc = bus.i_req_pulse[i];
            dec = (state == ISSUE) && (chan_id == ID_W'(i));
            at_max = &pending[i];
            // Saturated counter only holds; overflow only when nothing drains it this cycle.
            pend_nxt[i] = (inc && !dec) ? (at_max ? pending[i] : pending[i] + CNT_W'(1)) :
                          (!inc && dec) ? pending[i] - CNT_W'(1) : pending[i];
            ovf_set[i] = inc && !dec && at_max;
            nonzero_nxt[i] = pend_nxt[i] != '0;
        end
    end

    // Scan downward so the nearest nonzero requester after last_grant wins.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_grant) + k) % N_REQ);
            if (pending[idx] != '0) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_f or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_REQ; i++) pending[i] <= '0;
            overflow    <= '0;
            pending_any <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) pending[i] <= pend_nxt[i];
            overflow    <= (bus.i_ovf_clr ? '0 : overflow) | ovf_set;
            pending_any <= |nonzero_nxt;
        end
    end

    always_ff @(posedge i_clk_f or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            pluse      <= 1'b0;
            busy       <= 1'b0;
            chan_id    <= '0;
            gap        <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: if (bus.i_enable && found) begin
                    state      <= ISSUE;
                    chan_id    <= sel;
                    last_grant <= sel;
                    pluse      <= 1'b1;
                    busy       <= 1'b1;
                end
                ISSUE: begin
                    state <= HOLD;
                    pluse <= 1'b0;
                    gap   <= GAP_W'(MIN_GAP - 1);
                end
                HOLD: begin
                    gap <= gap - GAP_W'(1);
                    if (gap == GAP_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_pluse_f     = pluse;
    assign bus.o_chan_id     = chan_id;
    assign bus.o_busy        = busy;
    assign bus.o_pending_any = pending_any;
    assign bus.o_overflow    = overflow;
endmodule

// File: tb/tb_pulse_xing_scheduler.sv
// tb_pulse_xing_scheduler: directed checks of grant timing, fairness, saturation, enable and reset.
module tb_pulse_xing_scheduler;
    logic i_clk_f = 1'b0;
    logic i_reset = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    pulse_xing_scheduler_if #(.N_REQ(4)) bus ();

    pulse_xing_scheduler #(.N_REQ(4), .CNT_W(4), .MIN_GAP(8)) dut (
        .i_clk_f (i_clk_f),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    always #5 i_clk_f = ~i_clk_f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk_f);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_req_pulse = '0;
        bus.i_ovf_clr = 1'b0;
        tick();
        tick();
        i_reset = 1'b1;
    endtask

    // Ticks until o_pluse_f is seen; returns ticks taken or -1 if the limit expires.
    task automatic wait_pulse(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (bus.o_pluse_f) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int n, output int bad_id, input int want_id);
        n = 0;
        bad_id = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.o_pluse_f) begin
                n++;
                if (int'(bus.o_chan_id) != want_id) bad_id++;
            end
        end
    endtask

    initial begin
        int n, bad;
        int ids[$];
        int times[$];
        bus.i_enable = 1'b1;
        bus.i_req_pulse = '0;
        bus.i_ovf_clr = 1'b0;
        tick();
        check("reset_outputs", {bus.o_pluse_f, bus.o_chan_id, bus.o_busy, bus.o_pending_any, bus.o_overflow}, 0);
        tick();
        i_reset = 1'b1;

        // single pulse on req[2]
        bus.i_req_pulse = 4'b0100;
        tick();
        bus.i_req_pulse = '0;
        check("single_t1_pulse", bus.o_pluse_f, 0);
        check("single_t1_pending", bus.o_pending_any, 1);
        tick();
        check("single_t2_pulse", bus.o_pluse_f, 1);
        check("single_t2_id", bus.o_chan_id, 2);
        check("single_t2_busy", bus.o_busy, 1);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.o_pluse_f !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_chan_id !== 2'd2) bad++;
        end
        check("single_hold", bad, 0);
        tick();
        check("single_idle_busy", bus.o_busy, 0);
        check("single_idle_pending", bus.o_pending_any, 0);
        check("single_idle_id_held", bus.o_chan_id, 2);

        // all four at once, round-robin from 0
        do_reset();
        bus.i_req_pulse = 4'b1111;
        tick();
        bus.i_req_pulse = '0;
        wait_pulse(5, n);
        check("rr_first_lat", n, 1);
        check("rr_id0", bus.o_chan_id, 0);
        for (int k = 1; k < 4; k++) begin
            wait_pulse(20, n);
            check($sformatf("rr_gap%0d", k), n, 9);
            check($sformatf("rr_id%0d", k), bus.o_chan_id, k);
        end
        for (int i = 0; i < 9; i++) tick();
        check("rr_end_busy", bus.o_busy, 0);
        check("rr_end_pending", bus.o_pending_any, 0);

        // fairness: req[0] every cycle, one req[3] at cycle 5
        do_reset();
        for (int c = 0; c < 40; c++) begin
            bus.i_req_pulse = {c == 5, 2'b00, 1'b1};
            tick();
            if (bus.o_pluse_f) begin
                ids.push_back(int'(bus.o_chan_id));
                times.push_back(c);
            end
        end
        bus.i_req_pulse = '0;
        check("fair_count", ids.size(), 5);
        if (ids.size() >= 3) begin
            check("fair_id0", ids[0], 0);
            check("fair_id1", ids[1], 3);
            check("fair_id2", ids[2], 0);
            check("fair_t0", times[0], 1);
            check("fair_spacing", times[2] - times[1], 9);
        end
        check("fair_ovf", bus.o_overflow, 4'b0001);

        // saturation of req[1] while disabled
        do_reset();
        bus.i_enable = 1'b0;
        for (int c = 0; c < 17; c++) begin
            bus.i_req_pulse = 4'b0010;
            tick();
        end
        bus.i_req_pulse = '0;
        tick();
        check("sat_ovf", bus.o_overflow, 4'b0010);
        check("sat_pending", bus.o_pending_any, 1);
        check("sat_no_pulse", {bus.o_pluse_f, bus.o_busy}, 0);
        bus.i_enable = 1'b1;
        count_pulses(200, n, bad, 1);
        check("sat_grants", n, 15);
        check("sat_ids", bad, 0);
        check("sat_drained", bus.o_pending_any, 0);
        check("sat_ovf_sticky", bus.o_overflow, 4'b0010);
        bus.i_ovf_clr = 1'b1;
        tick();
        bus.i_ovf_clr = 1'b0;
        check("sat_ovf_clr", bus.o_overflow, 0);

        // enable dropped during HOLD
        do_reset();
        bus.i_enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.i_req_pulse = 4'b0001;
            tick();
        end
        bus.i_req_pulse = '0;
        bus.i_enable = 1'b1;
        wait_pulse(5, n);
        check("en_first", n, 1);
        tick();
        tick();
        bus.i_enable = 1'b0;
        count_pulses(30, n, bad, 0);
        check("en_blocked", n, 0);
        check("en_hold_done", bus.o_busy, 0);
        check("en_still_pending", bus.o_pending_any, 1);
        bus.i_enable = 1'b1;
        wait_pulse(5, n);
        check("en_resume_lat", n, 1);
        wait_pulse(20, n);
        check("en_resume_gap1", n, 9);
        wait_pulse(20, n);
        check("en_resume_gap2", n, 9);
        for (int i = 0; i < 12; i++) tick();
        check("en_end", {bus.o_busy, bus.o_pending_any}, 0);

        // asynchronous reset during HOLD with pending=5
        do_reset();
        bus.i_enable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.i_req_pulse = 4'b0100;
            tick();
        end
        bus.i_req_pulse = '0;
        bus.i_enable = 1'b1;
        wait_pulse(5, n);
        check("rst_first", n, 1);
        tick();
        tick();
        check("rst_pre_state", {bus.o_busy, bus.o_pending_any, bus.o_chan_id}, {1'b1, 1'b1, 2'd2});
        #3;
        i_reset = 1'b0;
        #1;
        check("rst_async", {bus.o_pluse_f, bus.o_chan_id, bus.o_busy, bus.o_pending_any, bus.o_overflow}, 0);
        tick();
        i_reset = 1'b1;
        count_pulses(50, n, bad, 0);
        check("rst_quiet", n, 0);
        check("rst_pending", bus.o_pending_any, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
